// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - command sequencer between the UART RX path, the ALU and the TX FIFO
module alu_cmd_ctrl #(
    parameter int          OP_W      = 8,
    parameter int          RES_BYTES = 2,
    parameter int          TIMEOUT   = 15,
    parameter logic [7:0]  CMD_OP    = 8'hCC,
    parameter logic [7:0]  CMD_FN    = 8'hDD
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [7:0]             RX_P_DATA,
    input  logic                   RX_D_VLD,
    input  logic [8*RES_BYTES-1:0] ALU_OUT,
    input  logic                   ALU_OUT_VLD,
    input  logic                   FIFO_FULL,
    output logic [OP_W-1:0]        ALU_A,
    output logic [OP_W-1:0]        ALU_B,
    output logic [3:0]             ALU_FUN,
    output logic                   ALU_EN,
    output logic                   CLK_GATE_EN,
    output logic [7:0]             WR_DATA,
    output logic                   WR_INC,
    output logic                   BUSY
);

    localparam int RES_W  = 8 * RES_BYTES;
    localparam int BCNT_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_GET_A, S_GET_B, S_GET_FUN, S_GATE_ON,
        S_ISSUE, S_WAIT, S_SEND, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic [3:0]          fun_q, fun_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                alu_en_q, alu_en_d;
    logic                gate_q, gate_d;
    logic                busy_q, busy_d;
    logic [RES_W-1:0]    res_shift;
    logic                wr_inc;
    logic [7:0]          wr_data;

    assign res_shift = res_q >> {bcnt_q, 3'b000};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        res_d   = res_q;
        bcnt_d  = bcnt_q;
        tmo_d   = tmo_q;
        wr_inc  = 1'b0;
        wr_data = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_OP) begin
                        state_d = S_GET_A;
                    end else if (RX_P_DATA == CMD_FN) begin
                        state_d = S_GET_FUN;
                    end
                end
            end
            S_GET_A: begin
                if (RX_D_VLD) begin
                    a_d     = OP_W'(RX_P_DATA);
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (RX_D_VLD) begin
                    b_d     = OP_W'(RX_P_DATA);
                    state_d = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (RX_D_VLD) begin
                    fun_d   = RX_P_DATA[3:0];
                    state_d = S_GATE_ON;
                end
            end
            S_GATE_ON: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ALU_OUT_VLD) begin
                    res_d   = ALU_OUT;
                    state_d = S_SEND;
                end else begin
                    // Abort on the cycle that would make the count reach TIMEOUT.
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_SEND: begin
                wr_data = res_shift[7:0];
                wr_inc  = ~FIFO_FULL;
                if (wr_inc) begin
                    if (bcnt_q == BCNT_W'(RES_BYTES - 1)) begin
                        bcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            S_ERR: begin
                wr_data = 8'hEE;
                wr_inc  = ~FIFO_FULL;
                if (wr_inc) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Control outputs are decoded from the next state so they come straight off flops.
        alu_en_d = (state_d == S_ISSUE);
        gate_d   = (state_d == S_GATE_ON) || (state_d == S_ISSUE) || (state_d == S_WAIT);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            res_q    <= '0;
            bcnt_q   <= '0;
            tmo_q    <= '0;
            alu_en_q <= 1'b0;
            gate_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fun_q    <= fun_d;
            res_q    <= res_d;
            bcnt_q   <= bcnt_d;
            tmo_q    <= tmo_d;
            alu_en_q <= alu_en_d;
            gate_q   <= gate_d;
            busy_q   <= busy_d;
        end
    end

    assign ALU_A       = a_q;
    assign ALU_B       = b_q;
    assign ALU_FUN     = fun_q;
    assign ALU_EN      = alu_en_q;
    assign CLK_GATE_EN = gate_q;
    assign BUSY        = busy_q;
    assign WR_DATA     = wr_data;
    assign WR_INC      = wr_inc;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - directed self-checking bench for alu_cmd_ctrl
module tb_alu_cmd_ctrl;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        FIFO_FULL;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic        CLK_GATE_EN;
    logic [7:0]  WR_DATA;
    logic        WR_INC;
    logic        BUSY;

    alu_cmd_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .CLK_GATE_EN(CLK_GATE_EN), .WR_DATA(WR_DATA), .WR_INC(WR_INC), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    int en_n   = 0;
    int gate_n = 0;
    int wr_n   = 0;
    logic [7:0] wr_log [0:255];

    always @(negedge CLK) begin
        if (ALU_EN) en_n++;
        if (CLK_GATE_EN) gate_n++;
        if (WR_INC) begin
            wr_log[wr_n % 256] = WR_DATA;
            wr_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'h00;
    endtask

    // Called in GATE_ON; ALU answers one cycle after ALU_EN is sampled; returns in the first SEND cycle.
    task automatic do_alu(input logic [15:0] res);
        tick();
        tick();
        ALU_OUT     = res;
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
    endtask

    int b0, e0, g0, n;

    initial begin
        RST = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
        ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
        tick(); tick();
        chk("rst_busy", BUSY, 0);
        chk("rst_a", ALU_A, 0);
        chk("rst_en", ALU_EN, 0);
        chk("rst_gate", CLK_GATE_EN, 0);
        chk("rst_wrinc", WR_INC, 0);
        chk("rst_wrdata", WR_DATA, 0);
        RST = 1'b1;
        tick();

        // CC 05 03 FUN=0 -> result 0008
        b0 = wr_n; e0 = en_n; g0 = gate_n;
        send(8'hCC); send(8'h05); send(8'h03); send(8'h00);
        chk("t1_gate_on", CLK_GATE_EN, 1);
        chk("t1_en_early", ALU_EN, 0);
        chk("t1_a", ALU_A, 8'h05);
        chk("t1_b", ALU_B, 8'h03);
        tick();
        chk("t1_en", ALU_EN, 1);
        tick();
        chk("t1_en_off", ALU_EN, 0);
        ALU_OUT = 16'h0008; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        chk("t1_gate_off", CLK_GATE_EN, 0);
        chk("t1_wrinc0", WR_INC, 1);
        chk("t1_wrdata0", WR_DATA, 8'h08);
        tick();
        chk("t1_wrdata1", WR_DATA, 8'h00);
        tick();
        chk("t1_busy_after", BUSY, 0);
        chk("t1_wr_count", wr_n - b0, 2);
        chk("t1_byte0", wr_log[b0 % 256], 8'h08);
        chk("t1_byte1", wr_log[(b0 + 1) % 256], 8'h00);
        chk("t1_en_pulses", en_n - e0, 1);
        chk("t1_gate_cycles", gate_n - g0, 3);

        // DD with upper nibble set on the FUN byte -> ALU_FUN = C, operands kept
        b0 = wr_n;
        send(8'hDD); send(8'hFC);
        chk("t2_fun", ALU_FUN, 4'hC);
        chk("t2_a", ALU_A, 8'h05);
        chk("t2_b", ALU_B, 8'h03);
        do_alu(16'h000A);
        chk("t2_wrdata0", WR_DATA, 8'h0A);
        tick();
        chk("t2_wrdata1", WR_DATA, 8'h00);
        tick();
        chk("t2_busy_after", BUSY, 0);
        chk("t2_wr_count", wr_n - b0, 2);
        chk("t2_byte0", wr_log[b0 % 256], 8'h0A);

        // BEEF with FIFO full for 5 cycles after SEND entry, plus a stall between bytes
        b0 = wr_n;
        send(8'hCC); send(8'h11); send(8'h22); send(8'h01);
        FIFO_FULL = 1'b1;
        do_alu(16'hBEEF);
        chk("t3_stall_wrinc", WR_INC, 0);
        chk("t3_stall_data", WR_DATA, 8'hEF);
        tick(); tick(); tick(); tick();
        chk("t3_stall_busy", BUSY, 1);
        chk("t3_no_writes", wr_n - b0, 0);
        tick();
        FIFO_FULL = 1'b0;
        #1;
        chk("t3_wrdata0", WR_DATA, 8'hEF);
        tick();
        FIFO_FULL = 1'b1;
        tick(); tick();
        chk("t3_mid_data", WR_DATA, 8'hBE);
        FIFO_FULL = 1'b0;
        tick();
        chk("t3_busy_after", BUSY, 0);
        chk("t3_wr_count", wr_n - b0, 2);
        chk("t3_byte0", wr_log[b0 % 256], 8'hEF);
        chk("t3_byte1", wr_log[(b0 + 1) % 256], 8'hBE);

        // ALU never answers -> 15 cycles in WAIT, one EE byte
        b0 = wr_n; e0 = en_n; g0 = gate_n;
        send(8'hCC); send(8'h01); send(8'h02); send(8'h03);
        tick(); tick();
        n = 0;
        while (!WR_INC && n < 40) begin
            tick();
            n++;
        end
        chk("t4_wait_cycles", n, 15);
        chk("t4_err_data", WR_DATA, 8'hEE);
        chk("t4_err_gate", CLK_GATE_EN, 0);
        tick();
        chk("t4_busy_after", BUSY, 0);
        chk("t4_wr_count", wr_n - b0, 1);
        chk("t4_byte", wr_log[b0 % 256], 8'hEE);
        chk("t4_en_pulses", en_n - e0, 1);
        chk("t4_gate_cycles", gate_n - g0, 17);

        b0 = wr_n;
        send(8'hCC); send(8'h07); send(8'h02); send(8'h01);
        do_alu(16'h0005);
        tick(); tick();
        chk("t4b_wr_count", wr_n - b0, 2);
        chk("t4b_byte0", wr_log[b0 % 256], 8'h05);

        // Garbage in IDLE, RX traffic during WAIT
        b0 = wr_n;
        send(8'h12);
        chk("t5_garbage_busy", BUSY, 0);
        send(8'hCC); send(8'h09); send(8'h04); send(8'h02);
        tick(); tick();
        send(8'hCC);
        send(8'h33);
        ALU_OUT = 16'h000D; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        chk("t5_a", ALU_A, 8'h09);
        chk("t5_wrdata0", WR_DATA, 8'h0D);
        tick(); tick();
        chk("t5_busy_after", BUSY, 0);
        chk("t5_wr_count", wr_n - b0, 2);
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        chk("t5_stray_vld", BUSY, 0);

        // Reset during SEND after the first byte
        b0 = wr_n;
        send(8'hCC); send(8'h21); send(8'h43); send(8'h00);
        do_alu(16'h1234);
        chk("t6_wrdata0", WR_DATA, 8'h34);
        tick();
        chk("t6_wrdata1_pending", WR_DATA, 8'h12);
        RST = 1'b0;
        #1;
        chk("t6_rst_wrinc", WR_INC, 0);
        chk("t6_rst_wrdata", WR_DATA, 0);
        chk("t6_rst_busy", BUSY, 0);
        chk("t6_rst_a", ALU_A, 0);
        chk("t6_rst_gate", CLK_GATE_EN, 0);
        tick();
        RST = 1'b1;
        tick();
        chk("t6_wr_count", wr_n - b0, 1);
        send(8'hDD); send(8'h00);
        chk("t6_dd_a", ALU_A, 0);
        chk("t6_dd_b", ALU_B, 0);
        chk("t6_dd_gate", CLK_GATE_EN, 1);
        do_alu(16'h0000);
        chk("t6_dd_wrinc", WR_INC, 1);
        tick(); tick();
        chk("t6_dd_busy_after", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command sequencer directly upstream of the ALU (arithmetic/logic/compare/shift units).
- Parses byte commands from the UART RX path and holds operands A/B.
- Gates the ALU clock on, issues one ALU_EN pulse with ALU_FUN, and captures the registered result.
- Streams the result LSB-first into the TX FIFO; reports a timeout error byte if the ALU never answers.

Parameters:
- OP_W, 8, operand width; one operand per RX byte (only 8 supported).
- RES_BYTES, 2, result bytes sent per operation (result width = 8*RES_BYTES).
- TIMEOUT, 15, cycles to wait for ALU_OUT_VLD after ALU_EN before aborting.
- CMD_OP, 8'hCC, command code "operands + function".
- CMD_FN, 8'hDD, command code "function only, reuse stored operands".

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  RX_P_DATA valid, one-cycle pulse per byte.
- ALU_OUT  in  8*RES_BYTES  ALU registered result.
- ALU_OUT_VLD  in  1  ALU result valid (registered, one cycle after ALU_EN sampled).
- FIFO_FULL  in  1  TX FIFO full.
- ALU_A  out  OP_W  operand A.
- ALU_B  out  OP_W  operand B.
- ALU_FUN  out  4  ALU function code, passed through unmodified.
- ALU_EN  out  1  ALU enable, single-cycle pulse.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- WR_DATA  out  8  byte to TX FIFO.
- WR_INC  out  1  TX FIFO write strobe.
- BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (RST low, async): state IDLE; ALU_A, ALU_B, ALU_FUN, WR_DATA = 0; ALU_EN, CLK_GATE_EN, WR_INC, BUSY = 0; byte counter and timeout counter = 0.
- States: IDLE, GET_A, GET_B, GET_FUN, GATE_ON, ISSUE, WAIT, SEND, ERR.
- IDLE: RX_D_VLD with CMD_OP -> GET_A; with CMD_FN -> GET_FUN; any other byte is dropped and the state stays IDLE.
- GET_A / GET_B: RX_D_VLD latches the byte into ALU_A / ALU_B, then advances (GET_A -> GET_B -> GET_FUN).
- GET_FUN: RX_D_VLD latches RX_P_DATA[3:0] into ALU_FUN; RX_P_DATA[7:4] are ignored; advance to GATE_ON.
- GATE_ON: one cycle. CLK_GATE_EN = 1 from here through WAIT, so the gated clock is stable one cycle before ALU_EN.
- ISSUE: one cycle. ALU_EN = 1; timeout counter cleared.
- WAIT:
  - ALU_OUT_VLD high: latch ALU_OUT into the result register and go to SEND; CLK_GATE_EN drops on the same edge.
  - Otherwise the counter increments; at count == TIMEOUT, go to ERR.
- Outputs ALU_EN, CLK_GATE_EN and BUSY are registered, i.e. decoded from the next state at the clock edge. They are glitch-free.
- Latency: FUN byte sampled at edge n -> CLK_GATE_EN high after n -> ALU_EN high during cycle n+1..n+2 -> ALU_OUT_VLD sampled at n+3 -> first WR_INC in cycle n+3..n+4 if the FIFO is not full.
- SEND:
  - WR_DATA = result byte [8*i+7:8*i], where i is the byte counter (LSB first).
  - WR_INC = ~FIFO_FULL (combinational on state and FIFO_FULL).
  - i advances on each edge with WR_INC high; after byte RES_BYTES-1 is written, go to IDLE and clear i.
  - FIFO_FULL stalls indefinitely with no byte lost or duplicated.
- ERR: WR_DATA = 8'hEE, WR_INC = ~FIFO_FULL; go to IDLE on the write edge. CLK_GATE_EN = 0.
- RX_D_VLD in GATE_ON, ISSUE, WAIT, SEND or ERR: byte dropped, no state effect.
- ALU_OUT_VLD outside WAIT: ignored.
- Operands persist across commands.
  - CMD_FN reuses the last ALU_A/ALU_B values.
  - CMD_FN after reset uses 0/0.
- Reset mid-operation (any state): immediate return to IDLE. Pending result discarded; no partial FIFO write completes after RST falls.

Test Plan:
- CC,05,03,FUN=0 with ALU_OUT=16'h0008 returned one cycle after ALU_EN -> ALU_A=05, ALU_B=03, one ALU_EN pulse, CLK_GATE_EN high exactly 3 cycles, FIFO receives 08 then 00 on consecutive cycles, BUSY low after.
- DD,FUN=4'hC following the above, ALU_OUT=16'h000A -> no operand change, ALU_FUN=C, FIFO gets 0A,00; byte DD with upper nibble 4'hF on the FUN byte -> ALU_FUN still uses [3:0] only.
- Result 16'hBEEF with FIFO_FULL held high 5 cycles after SEND entry -> no WR_INC during stall; then EF, BE written once each in order.
- ALU_OUT_VLD never asserted -> exactly TIMEOUT cycles in WAIT, single write of EE, CLK_GATE_EN low, return to IDLE; next CC command works normally.
- Garbage 0x12 in IDLE and extra RX bytes during WAIT -> ignored; no state change, no FIFO writes beyond the expected result.
- RST asserted during SEND after first byte written -> all outputs 0 asynchronously, no second byte; after release a DD command computes with A=B=0.
